// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the crossbar write-address scheduler.
package axi_xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int QOS_W = 4;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_crossbar_aw_sched_if.sv
// AW request / grant / W-routing signal bundle of one crossbar master port.
// The master modport is the scheduler's view; slave is its environment.
interface axi_crossbar_aw_sched_if
    import axi_xbar_pkg::*;
#(
    parameter int S_COUNT = 4,
    parameter int SEL_W   = clog2(S_COUNT)
);

    logic [S_COUNT-1:0]       s_req_valid;
    logic [QOS_W*S_COUNT-1:0] s_req_qos;
    logic [S_COUNT-1:0]       s_req_ready;
    logic                     m_grant_valid;
    logic [SEL_W-1:0]         m_grant_sel;
    logic                     m_aready;
    logic [SEL_W-1:0]         w_sel;
    logic                     w_sel_valid;
    logic                     w_last_hs;
    logic                     err_underflow;

    modport master (
        input  s_req_valid,
        input  s_req_qos,
        input  m_aready,
        input  w_last_hs,
        output s_req_ready,
        output m_grant_valid,
        output m_grant_sel,
        output w_sel,
        output w_sel_valid,
        output err_underflow
    );

    modport slave (
        output s_req_valid,
        output s_req_qos,
        output m_aready,
        output w_last_hs,
        input  s_req_ready,
        input  m_grant_valid,
        input  m_grant_sel,
        input  w_sel,
        input  w_sel_valid,
        input  err_underflow
    );

endinterface

// File: rtl/axi_sel_fifo.sv
// In-order FIFO of granted source indices. The head is registered so the
// W mux select comes straight from a flop; pop on an empty FIFO is dropped
// and reported through underflow.
module axi_sel_fifo
    import axi_xbar_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SEL_W-1:0] push_data,
    input  logic             pop,
    output logic [SEL_W-1:0] head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    localparam int PTR_W = clog2(FIFO_DEPTH);

    logic [SEL_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_next;
    logic [SEL_W-1:0] head_next;
    logic             pop_eff;

    // Next pointer/count and the value the head register will hold next cycle.
    always_comb begin
        pop_eff         = pop && (count != '0);
        underflow       = pop && (count == '0);
        rd_ptr_next     = rd_ptr + PTR_W'(pop_eff);
        count_after_pop = count - CNT_W'(pop_eff);
        count_next      = count_after_pop + CNT_W'(push);
        if (count_next == '0) begin
            head_next = '0;
        end else if (count_after_pop == '0) begin
            // The entry being written now becomes the head.
            head_next = push_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage array; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(push);
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head       <= head_next;
            head_valid <= (count_next != '0);
        end
    end

endmodule

// File: rtl/axi_crossbar_aw_sched.sv
// Write-address scheduler for one crossbar master port: round-robin AW
// arbitration with at most one grant in flight, plus an in-order FIFO of
// granted sources that steers the W-channel mux.
// Optional feature macro: AXI_XBAR_AW_QOS_EN restricts the round-robin
// candidates to the requests carrying the highest awqos.
module axi_crossbar_aw_sched
    import axi_xbar_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_W      = clog2(S_COUNT)
) (
    input logic                     clk,
    input logic                     rst,
    axi_crossbar_aw_sched_if.master bus
);

    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   grant_sel;
    logic [SEL_W-1:0]   last_grant;
    logic [S_COUNT-1:0] cand;
    logic               cand_any;
    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   idx;
    logic               load_grant;
    logic               push;
    logic [S_COUNT-1:0] ready;
    logic [CNT_W-1:0]   count;
    logic               fifo_underflow;
    logic               err_underflow;

`ifdef AXI_XBAR_AW_QOS_EN
    logic [QOS_W-1:0] max_qos;

    // Candidates are the valid requests at the highest awqos present.
    always_comb begin
        max_qos = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (bus.s_req_valid[i] && (bus.s_req_qos[QOS_W*i +: QOS_W] > max_qos)) begin
                max_qos = bus.s_req_qos[QOS_W*i +: QOS_W];
            end
        end
        cand = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            cand[i] = bus.s_req_valid[i] && (bus.s_req_qos[QOS_W*i +: QOS_W] == max_qos);
        end
    end
`else
    logic unused_qos;
    assign unused_qos = ^bus.s_req_qos;
    assign cand = bus.s_req_valid;
`endif

    // Round-robin pick: first candidate after the last granted source.
    always_comb begin
        pick     = '0;
        cand_any = 1'b0;
        idx      = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            idx = SEL_W'((int'(last_grant) + k) % S_COUNT);
            if (!cand_any && cand[idx]) begin
                pick     = idx;
                cand_any = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: grant only when the FIFO can absorb the push; release on awready.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (cand_any && (count < CNT_W'(FIFO_DEPTH))) begin
                    state_next = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (bus.m_aready) begin
                    state_next = IDLE;
                    push       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Granted index is frozen for the whole GRANT state; priority moves on handshake only.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_sel  <= '0;
            last_grant <= SEL_W'(S_COUNT - 1);
        end else begin
            if (load_grant) begin
                grant_sel <= pick;
            end
            if (push) begin
                last_grant <= grant_sel;
            end
        end
    end

    // One-hot accept back to the granted source, passing awready through.
    always_comb begin
        ready = '0;
        if (state == GRANT) begin
            ready[grant_sel] = bus.m_aready;
        end
    end

    // Sticky record of a W last beat arriving with no burst outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (fifo_underflow) begin
            err_underflow <= 1'b1;
        end
    end

    axi_sel_fifo #(
        .SEL_W      (SEL_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (grant_sel),
        .pop        (bus.w_last_hs),
        .head       (bus.w_sel),
        .head_valid (bus.w_sel_valid),
        .count      (count),
        .underflow  (fifo_underflow)
    );

    assign bus.s_req_ready   = ready;
    assign bus.m_grant_valid = (state == GRANT);
    assign bus.m_grant_sel   = grant_sel;
    assign bus.err_underflow = err_underflow;

endmodule

// File: tb/tb_axi_crossbar_aw_sched.sv
// Directed bench for the AW scheduler: reset values, single grant, fairness,
// FIFO-full back-pressure, push+pop, underflow flag, qos selection, mid-grant reset.
module tb_axi_crossbar_aw_sched;

    localparam int S_COUNT    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int SEL_W      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_order [5] = '{0, 1, 2, 3, 0};
    int   exp_qos_sel;

    axi_crossbar_aw_sched_if #(.S_COUNT(S_COUNT), .SEL_W(SEL_W)) bus ();

    axi_crossbar_aw_sched #(
        .S_COUNT    (S_COUNT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SEL_W      (SEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.s_req_valid = '0;
        bus.s_req_qos   = '0;
        bus.m_aready    = 1'b0;
        bus.w_last_hs   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_gvalid", bus.m_grant_valid, 0);
        check("rst_gsel", bus.m_grant_sel, 0);
        check("rst_ready", bus.s_req_ready, 0);
        check("rst_wsel", bus.w_sel, 0);
        check("rst_wvalid", bus.w_sel_valid, 0);
        check("rst_err", bus.err_underflow, 0);

        // Single source 2
        bus.s_req_valid = 4'b0100;
        tick();
        check("single_gvalid", bus.m_grant_valid, 1);
        check("single_gsel", bus.m_grant_sel, 2);
        check("single_ready_wait", bus.s_req_ready, 0);
        bus.m_aready = 1'b1;
        #1;
        check("single_ready", bus.s_req_ready, 4'b0100);
        tick();
        check("single_wsel", bus.w_sel, 2);
        check("single_wvalid", bus.w_sel_valid, 1);
        check("single_bubble", bus.m_grant_valid, 0);
        bus.s_req_valid = '0;
        bus.m_aready    = 1'b0;
        bus.w_last_hs   = 1'b1;
        tick();
        bus.w_last_hs = 1'b0;
        check("single_popped", bus.w_sel_valid, 0);
        check("single_no_err", bus.err_underflow, 0);

        // Fairness: all four requesting, awready high, one pop in cycle 7
        do_reset();
        bus.s_req_valid = 4'b1111;
        bus.m_aready    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.w_last_hs = (c == 7);
            if ((c % 2) == 1) begin
                check("fair_gvalid", bus.m_grant_valid, 1);
                check("fair_gsel", bus.m_grant_sel, exp_order[c/2]);
            end else begin
                check("fair_bubble", bus.m_grant_valid, 0);
            end
            if (c == 8) check("fair_wsel_after_pop", bus.w_sel, 1);
        end

        // Full FIFO back-pressure and W select order
        do_reset();
        bus.s_req_valid = 4'b1111;
        bus.m_aready    = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 8) bus.m_aready = 1'b0;
            bus.w_last_hs = (c == 11) || (c >= 13 && c <= 15);
            if (c == 8) check("full_wsel_head", bus.w_sel, 0);
            if (c >= 8 && c <= 12) check("full_blocked", bus.m_grant_valid, 0);
            if (c == 12) check("full_wsel_adv", bus.w_sel, 1);
            if (c == 13) begin
                check("full_regrant_gvalid", bus.m_grant_valid, 1);
                check("full_regrant_gsel", bus.m_grant_sel, 0);
            end
            if (c == 14) check("full_wsel_2", bus.w_sel, 2);
            if (c == 15) check("full_wsel_3", bus.w_sel, 3);
            if (c == 16) begin
                check("full_drained", bus.w_sel_valid, 0);
                check("full_grant_held", bus.m_grant_valid, 1);
                check("full_no_err", bus.err_underflow, 0);
            end
        end

        // Simultaneous push and pop with two entries outstanding
        do_reset();
        bus.s_req_valid = 4'b0011;
        bus.m_aready    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.w_last_hs = (c >= 5 && c <= 7);
            if (c == 6) bus.s_req_valid = '0;
            if (c == 4) begin
                check("pp_head0", bus.w_sel, 0);
                check("pp_valid0", bus.w_sel_valid, 1);
            end
            if (c == 5) begin
                check("pp_gvalid", bus.m_grant_valid, 1);
                check("pp_gsel", bus.m_grant_sel, 0);
            end
            if (c == 6) begin
                check("pp_head1", bus.w_sel, 1);
                check("pp_valid1", bus.w_sel_valid, 1);
                check("pp_idle", bus.m_grant_valid, 0);
            end
            if (c == 7) begin
                check("pp_head2", bus.w_sel, 0);
                check("pp_valid2", bus.w_sel_valid, 1);
            end
            if (c == 8) begin
                check("pp_empty", bus.w_sel_valid, 0);
                check("pp_no_err", bus.err_underflow, 0);
            end
        end

        // Underflow: pop on empty sets sticky flag, count stays zero
        do_reset();
        bus.w_last_hs = 1'b1;
        tick();
        bus.w_last_hs = 1'b0;
        check("uf_err", bus.err_underflow, 1);
        check("uf_empty", bus.w_sel_valid, 0);
        tick();
        tick();
        tick();
        check("uf_sticky", bus.err_underflow, 1);
        bus.s_req_valid = 4'b0001;
        bus.m_aready    = 1'b1;
        tick();
        check("uf_grant", bus.m_grant_valid, 1);
        tick();
        bus.s_req_valid = '0;
        bus.m_aready    = 1'b0;
        check("uf_one_entry", bus.w_sel_valid, 1);
        bus.w_last_hs = 1'b1;
        tick();
        bus.w_last_hs = 1'b0;
        check("uf_count_zero", bus.w_sel_valid, 0);
        check("uf_still_set", bus.err_underflow, 1);
        do_reset();
        check("uf_cleared", bus.err_underflow, 0);

        // QoS selection after last_grant moved to 0, then reset mid-grant
        bus.s_req_valid = 4'b0001;
        bus.m_aready    = 1'b1;
        tick();
        tick();
        bus.s_req_valid = 4'b1010;
        bus.s_req_qos   = 16'h7010;
        bus.m_aready    = 1'b0;
        tick();
`ifdef AXI_XBAR_AW_QOS_EN
        exp_qos_sel = 3;
`else
        exp_qos_sel = 1;
`endif
        check("qos_gvalid", bus.m_grant_valid, 1);
        check("qos_gsel", bus.m_grant_sel, exp_qos_sel);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_gvalid", bus.m_grant_valid, 0);
        check("midrst_wvalid", bus.w_sel_valid, 0);
        check("midrst_ready", bus.s_req_ready, 0);
        check("midrst_gsel", bus.m_grant_sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
